// File: rtl/mci_pkg.sv
// Shared types and constants for the MCI MCU SRAM controller.
// Optional SECDED ECC is enabled with MCI_MCU_SRAM_ECC_EN.
package mci_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        RMW_RD,
        RMW_WR
    } mci_mcu_sram_state_e;

    localparam int MCI_MCU_SRAM_ECC_W = 7;
    localparam int MCI_MCU_SRAM_EXEC_GRAN_WORDS = 1024;

    // Hamming position of data bit idx; powers of two hold check bits
    function automatic logic [5:0] mci_secded_pos(input int idx);
        int n;
        logic [5:0] p;
        p = 6'd0;
        n = 0;
        for (int q = 1; q < 39; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == idx) p = 6'(q);
                n++;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mci_mcu_sram_secded.sv
// Combinational Hamming SECDED (39,32) encoder and checker/corrector.
// Used by mci_mcu_sram_ctrl only when MCI_MCU_SRAM_ECC_EN is defined.
module mci_mcu_sram_secded
    import mci_pkg::*;
(
    input  logic [31:0] enc_data,
    output logic [6:0]  enc_ecc,
    input  logic [31:0] dec_data,
    input  logic [6:0]  dec_ecc,
    output logic [31:0] dec_corr,
    output logic        dec_sb,
    output logic        dec_db
);

    logic [5:0] dpar;
    logic [5:0] syn;
    logic [5:0] pos;
    logic       odd;

    always_comb begin
        enc_ecc = '0;
        dpar = '0;
        pos = '0;
        for (int j = 0; j < 32; j++) begin
            pos = mci_secded_pos(j);
            for (int i = 0; i < 6; i++) begin
                enc_ecc[i] = enc_ecc[i] ^ (enc_data[j] & pos[i]);
                dpar[i] = dpar[i] ^ (dec_data[j] & pos[i]);
            end
        end
        enc_ecc[6] = ^{enc_data, enc_ecc[5:0]};
    end

    // Syndrome 0 with odd parity means the overall check bit itself flipped
    always_comb begin
        syn = dpar ^ dec_ecc[5:0];
        odd = ^{dec_data, dec_ecc};
        dec_corr = dec_data;
        for (int j = 0; j < 32; j++) begin
            if (syn == mci_secded_pos(j)) dec_corr[j] = ~dec_data[j];
        end
        dec_sb = odd && (syn <= 6'd38);
        dec_db = (!odd && (syn != 6'd0)) || (odd && (syn > 6'd38));
    end

endmodule

// File: rtl/mci_mcu_sram_ctrl.sv
// MCU SRAM request controller: read wait state, RMW partial writes,
// exec-region write protection, optional SECDED (MCI_MCU_SRAM_ECC_EN).
module mci_mcu_sram_ctrl
    import mci_pkg::*;
#(
    parameter  int MCU_SRAM_SIZE_KB = 512,
    localparam int SRAM_AW = $clog2(MCU_SRAM_SIZE_KB * 256)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cif_dv,
    input  logic [31:0]        cif_addr,
    input  logic               cif_write,
    input  logic [31:0]        cif_wdata,
    input  logic [3:0]         cif_wstrb,
    input  logic               axi_mcu_req,
    input  logic               axi_mcu_sram_config_req,
    output logic               cif_hold,
    output logic [31:0]        cif_rdata,
    output logic               cif_error,
    input  logic               fw_exec_region_lock,
    input  logic [15:0]        exec_region_size,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [38:0]        sram_wdata,
    input  logic [38:0]        sram_rdata,
    output logic               ecc_sb_err,
    output logic               ecc_db_err,
    output logic [15:0]        ecc_sb_count
);

    mci_mcu_sram_state_e state_q, state_d;

    logic [31:0]                   merge_q, merge_d;
    logic [SRAM_AW-1:0]            word;
    logic [31:0]                   region_end;
    logic                          prot_err;
    logic                          req;
    logic [31:0]                   wr_data;
    logic [MCI_MCU_SRAM_ECC_W-1:0] wr_ecc;
    logic [31:0]                   rd_corr;
    logic [31:0]                   rd_merge;
    logic                          rd_sb, rd_db;
    logic                          sb_evt, db_evt;

    assign word = cif_addr[SRAM_AW+1:2];
    assign region_end = (32'(exec_region_size) + 32'd1)
                      * 32'(MCI_MCU_SRAM_EXEC_GRAN_WORDS);
    assign prot_err = cif_write && (32'(word) < region_end) &&
                      (fw_exec_region_lock ? !axi_mcu_req
                                           : !axi_mcu_sram_config_req);

    // Reset gates the request so the SRAM is released at once
    assign req = cif_dv && !rst;
    assign wr_data = (state_q == RMW_WR) ? merge_q : cif_wdata;
    assign sram_addr = word;
    assign sram_wdata = {wr_ecc, wr_data};

    always_comb begin
        rd_merge = rd_corr;
        for (int b = 0; b < 4; b++) begin
            if (cif_wstrb[b]) rd_merge[8*b +: 8] = cif_wdata[8*b +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        sram_cs = 1'b0;
        sram_we = 1'b0;
        cif_hold = 1'b0;
        cif_rdata = '0;
        cif_error = 1'b0;
        sb_evt = 1'b0;
        db_evt = 1'b0;
        if (!req) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (prot_err) begin
                        cif_error = 1'b1;
                    end else begin
                        sram_cs = 1'b1;
                        if (!cif_write) begin
                            cif_hold = 1'b1;
                            state_d = RD_DATA;
                        end else if (cif_wstrb == 4'hF) begin
                            sram_we = 1'b1;
                        end else begin
                            cif_hold = 1'b1;
                            state_d = RMW_RD;
                        end
                    end
                end
                RD_DATA: begin
                    cif_rdata = rd_db ? 32'd0 : rd_corr;
                    cif_error = rd_db;
                    sb_evt = rd_sb;
                    db_evt = rd_db;
                    state_d = IDLE;
                end
                RMW_RD: begin
                    sb_evt = rd_sb;
                    db_evt = rd_db;
                    if (rd_db) begin
                        cif_error = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cif_hold = 1'b1;
                        merge_d = rd_merge;
                        state_d = RMW_WR;
                    end
                end
                RMW_WR: begin
                    sram_cs = 1'b1;
                    sram_we = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

`ifdef MCI_MCU_SRAM_ECC_EN
    mci_mcu_sram_secded u_secded (
        .enc_data (wr_data),
        .enc_ecc  (wr_ecc),
        .dec_data (sram_rdata[31:0]),
        .dec_ecc  (sram_rdata[38:32]),
        .dec_corr (rd_corr),
        .dec_sb   (rd_sb),
        .dec_db   (rd_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ecc_sb_err <= 1'b0;
            ecc_db_err <= 1'b0;
            ecc_sb_count <= '0;
        end else begin
            ecc_sb_err <= sb_evt;
            ecc_db_err <= db_evt;
            if (sb_evt && ecc_sb_count != 16'hFFFF)
                ecc_sb_count <= ecc_sb_count + 16'd1;
        end
    end
`else
    assign wr_ecc = '0;
    assign rd_corr = sram_rdata[31:0];
    assign rd_sb = 1'b0;
    assign rd_db = 1'b0;
    assign ecc_sb_err = 1'b0;
    assign ecc_db_err = 1'b0;
    assign ecc_sb_count = '0;

    logic unused_ecc;
    assign unused_ecc = ^{sram_rdata[38:32], sb_evt, db_evt};
`endif

    logic unused_addr;
    assign unused_addr = ^{cif_addr[31:SRAM_AW+2], cif_addr[1:0]};

`ifndef SYNTHESIS
    a_dv_held: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE) |-> cif_dv);
`endif

endmodule

// File: tb/tb_mci_mcu_sram_ctrl.sv
// Directed testbench for mci_mcu_sram_ctrl with a 1-cycle SRAM model.
// Expectations follow MCI_MCU_SRAM_ECC_EN when it is defined.
module tb_mci_mcu_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cif_dv = 1'b0;
    logic [31:0] cif_addr = '0;
    logic        cif_write = 1'b0;
    logic [31:0] cif_wdata = '0;
    logic [3:0]  cif_wstrb = '0;
    logic        axi_mcu_req = 1'b1;
    logic        axi_mcu_sram_config_req = 1'b0;
    logic        cif_hold;
    logic [31:0] cif_rdata;
    logic        cif_error;
    logic        fw_exec_region_lock = 1'b1;
    logic [15:0] exec_region_size = '0;
    logic        sram_cs;
    logic        sram_we;
    logic [16:0] sram_addr;
    logic [38:0] sram_wdata;
    logic [38:0] sram_rdata;
    logic        ecc_sb_err;
    logic        ecc_db_err;
    logic [15:0] ecc_sb_count;

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mci_mcu_sram_ctrl #(.MCU_SRAM_SIZE_KB(512)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cif_dv                  (cif_dv),
        .cif_addr                (cif_addr),
        .cif_write               (cif_write),
        .cif_wdata               (cif_wdata),
        .cif_wstrb               (cif_wstrb),
        .axi_mcu_req             (axi_mcu_req),
        .axi_mcu_sram_config_req (axi_mcu_sram_config_req),
        .cif_hold                (cif_hold),
        .cif_rdata               (cif_rdata),
        .cif_error               (cif_error),
        .fw_exec_region_lock     (fw_exec_region_lock),
        .exec_region_size        (exec_region_size),
        .sram_cs                 (sram_cs),
        .sram_we                 (sram_we),
        .sram_addr               (sram_addr),
        .sram_wdata              (sram_wdata),
        .sram_rdata              (sram_rdata),
        .ecc_sb_err              (ecc_sb_err),
        .ecc_db_err              (ecc_db_err),
        .ecc_sb_count            (ecc_sb_count)
    );

    logic [38:0] mem [0:131071];
    logic [38:0] rdq = '0;
    logic [38:0] flip = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rdq <= mem[sram_addr];
            end
        end
    end

    assign sram_rdata = rdq ^ flip;

    int          h;
    int          w0;
    logic [31:0] d;
    logic        e, c, sp, dp;

    task automatic req(input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] st,
                       output int holds, output logic [31:0] rd,
                       output logic err, output logic cs,
                       output logic sbp, output logic dbp);
        @(negedge clk);
        cif_dv = 1'b1;
        cif_addr = a;
        cif_write = w;
        cif_wdata = wd;
        cif_wstrb = st;
        holds = 0;
        #1;
        while (cif_hold && holds < 8) begin
            holds++;
            @(negedge clk);
            #1;
        end
        if (cif_hold) holds = 99;
        rd = cif_rdata;
        err = cif_error;
        cs = sram_cs;
        @(posedge clk);
        #1;
        cif_dv = 1'b0;
        cif_write = 1'b0;
        sbp = ecc_sb_err;
        dbp = ecc_db_err;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vec++;
        if ({cif_hold, sram_cs, sram_we, cif_error, ecc_sb_err, ecc_db_err} !== 6'b0
            || cif_rdata !== 32'd0 || ecc_sb_count !== 16'd0) begin
            miss++;
            $display("FAIL reset_outputs: got hold=%b cs=%b we=%b err=%b rdata=%h cnt=%h want all 0",
                     cif_hold, sram_cs, sram_we, cif_error, cif_rdata, ecc_sb_count);
        end
        cif_dv = 1'b1;
        #1;
        vec++;
        if (sram_cs !== 1'b0) begin
            miss++;
            $display("FAIL reset_gates_cs: got %b want 0", sram_cs);
        end
        cif_dv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_write_read();
        w0 = wr_cnt;
        req(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (h !== 0 || e !== 1'b0 || c !== 1'b1) begin
            miss++;
            $display("FAIL full_write: got holds=%0d err=%b cs=%b want 0 0 1", h, e, c);
        end
        vec++;
        if (wr_cnt - w0 !== 1) begin
            miss++;
            $display("FAIL full_write_count: got %0d want 1", wr_cnt - w0);
        end
`ifndef MCI_MCU_SRAM_ECC_EN
        vec++;
        if (mem[17'h40][38:32] !== 7'd0) begin
            miss++;
            $display("FAIL ecc_bits_zero: got %h want 0", mem[17'h40][38:32]);
        end
`endif
        req(32'h100, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (h !== 1 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            miss++;
            $display("FAIL full_read: got holds=%0d data=%h err=%b want 1 deadbeef 0", h, d, e);
        end
    endtask

    task automatic test_partial_write();
        req(32'h40, 1'b1, 32'h11223344, 4'hF, h, d, e, c, sp, dp);
        w0 = wr_cnt;
        req(32'h40, 1'b1, 32'hAABBCCDD, 4'b0101, h, d, e, c, sp, dp);
        vec++;
        if (h !== 2 || e !== 1'b0 || c !== 1'b1 || wr_cnt - w0 !== 1) begin
            miss++;
            $display("FAIL partial_write: got holds=%0d err=%b cs=%b writes=%0d want 2 0 1 1",
                     h, e, c, wr_cnt - w0);
        end
        req(32'h40, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (d !== 32'h11BB33DD) begin
            miss++;
            $display("FAIL partial_merge: got %h want 11bb33dd", d);
        end
        w0 = wr_cnt;
        req(32'h40, 1'b1, 32'hFFFFFFFF, 4'h0, h, d, e, c, sp, dp);
        req(32'h40, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (d !== 32'h11BB33DD || wr_cnt - w0 !== 1) begin
            miss++;
            $display("FAIL zero_strobe: got %h writes=%0d want 11bb33dd 1", d, wr_cnt - w0);
        end
        req(32'h40, 1'b1, 32'h99000000, 4'b1000, h, d, e, c, sp, dp);
        req(32'h40, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (d !== 32'h99BB33DD) begin
            miss++;
            $display("FAIL top_byte: got %h want 99bb33dd", d);
        end
    endtask

    task automatic test_protection();
        axi_mcu_req = 1'b0;
        axi_mcu_sram_config_req = 1'b1;
        w0 = wr_cnt;
        req(32'hFFC, 1'b1, 32'h12345678, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b1 || h !== 0 || c !== 1'b0 || wr_cnt != w0) begin
            miss++;
            $display("FAIL prot_lock1_3ff: got err=%b holds=%0d cs=%b writes=%0d want 1 0 0 0",
                     e, h, c, wr_cnt - w0);
        end
        req(32'hFFC, 1'b1, 32'h12345678, 4'h1, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b1 || h !== 0 || c !== 1'b0) begin
            miss++;
            $display("FAIL prot_partial: got err=%b holds=%0d cs=%b want 1 0 0", e, h, c);
        end
        req(32'h1000, 1'b1, 32'h12345678, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b0 || wr_cnt - w0 !== 1) begin
            miss++;
            $display("FAIL prot_400_free: got err=%b writes=%0d want 0 1", e, wr_cnt - w0);
        end
        fw_exec_region_lock = 1'b0;
        req(32'hFFC, 1'b1, 32'hCAFEF00D, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b0) begin
            miss++;
            $display("FAIL prot_lock0_cfg: got err=%b want 0", e);
        end
        req(32'hFFC, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (d !== 32'hCAFEF00D) begin
            miss++;
            $display("FAIL prot_readback: got %h want cafef00d", d);
        end
        axi_mcu_req = 1'b1;
        axi_mcu_sram_config_req = 1'b0;
        req(32'hFFC, 1'b1, 32'h0, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b1) begin
            miss++;
            $display("FAIL prot_lock0_mcu: got err=%b want 1", e);
        end
        fw_exec_region_lock = 1'b1;
        axi_mcu_req = 1'b0;
        exec_region_size = 16'd1;
        req(32'h1FFC, 1'b1, 32'h0, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b1) begin
            miss++;
            $display("FAIL prot_size1_7ff: got err=%b want 1", e);
        end
        req(32'h2000, 1'b1, 32'h0, 4'hF, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b0) begin
            miss++;
            $display("FAIL prot_size1_800: got err=%b want 0", e);
        end
        exec_region_size = 16'd0;
        axi_mcu_req = 1'b1;
    endtask

    task automatic test_back_to_back();
        req(32'h200, 1'b1, 32'hA5A5A5A5, 4'hF, h, d, e, c, sp, dp);
        req(32'h200, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (h !== 1 || d !== 32'hA5A5A5A5) begin
            miss++;
            $display("FAIL back_to_back: got holds=%0d data=%h want 1 a5a5a5a5", h, d);
        end
    endtask

    task automatic test_ecc();
        flip = 39'h20;
        req(32'h100, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        flip = '0;
`ifdef MCI_MCU_SRAM_ECC_EN
        vec++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || sp !== 1'b1 || ecc_sb_count !== 16'd1) begin
            miss++;
            $display("FAIL ecc_sb: got data=%h err=%b sb=%b cnt=%0d want deadbeef 0 1 1",
                     d, e, sp, ecc_sb_count);
        end
`else
        vec++;
        if (d !== 32'hDEADBECF || e !== 1'b0 || sp !== 1'b0 || ecc_sb_count !== 16'd0) begin
            miss++;
            $display("FAIL noecc_flip5: got data=%h err=%b sb=%b cnt=%0d want deadbecf 0 0 0",
                     d, e, sp, ecc_sb_count);
        end
`endif
        flip = 39'h208;
        req(32'h100, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
`ifdef MCI_MCU_SRAM_ECC_EN
        vec++;
        if (d !== 32'd0 || e !== 1'b1 || dp !== 1'b1 || ecc_sb_count !== 16'd1) begin
            miss++;
            $display("FAIL ecc_db: got data=%h err=%b db=%b cnt=%0d want 0 1 1 1",
                     d, e, dp, ecc_sb_count);
        end
        w0 = wr_cnt;
        req(32'h40, 1'b1, 32'h00000055, 4'h1, h, d, e, c, sp, dp);
        vec++;
        if (e !== 1'b1 || h !== 1 || wr_cnt != w0) begin
            miss++;
            $display("FAIL ecc_db_rmw: got err=%b holds=%0d writes=%0d want 1 1 0",
                     e, h, wr_cnt - w0);
        end
`else
        vec++;
        if (d !== 32'hDEADBCE7 || e !== 1'b0 || dp !== 1'b0) begin
            miss++;
            $display("FAIL noecc_flip39: got data=%h err=%b db=%b want deadbce7 0 0", d, e, dp);
        end
`endif
        flip = 39'h20;
        req(32'h200, 1'b1, 32'h0000003C, 4'h1, h, d, e, c, sp, dp);
        flip = '0;
        req(32'h200, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
`ifdef MCI_MCU_SRAM_ECC_EN
        if (d !== 32'hA5A5A53C || ecc_sb_count !== 16'd2) begin
            miss++;
            $display("FAIL ecc_sb_rmw: got data=%h cnt=%0d want a5a5a53c 2", d, ecc_sb_count);
        end
`else
        if (d !== 32'hA5A5A53C || ecc_sb_count !== 16'd0) begin
            miss++;
            $display("FAIL noecc_rmw: got data=%h cnt=%0d want a5a5a53c 0", d, ecc_sb_count);
        end
`endif
    endtask

    task automatic test_reset_rmw();
        w0 = wr_cnt;
        @(negedge clk);
        cif_dv = 1'b1;
        cif_addr = 32'h40;
        cif_write = 1'b1;
        cif_wdata = 32'h00000055;
        cif_wstrb = 4'h1;
        #1;
        vec++;
        if (cif_hold !== 1'b1 || sram_cs !== 1'b1) begin
            miss++;
            $display("FAIL rmw_issue: got hold=%b cs=%b want 1 1", cif_hold, sram_cs);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (sram_cs !== 1'b0 || sram_we !== 1'b0) begin
            miss++;
            $display("FAIL rst_mid_cs: got cs=%b we=%b want 0 0", sram_cs, sram_we);
        end
        @(negedge clk);
        cif_dv = 1'b0;
        cif_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec++;
        if (ecc_sb_count !== 16'd0 || wr_cnt != w0) begin
            miss++;
            $display("FAIL rst_mid_state: got cnt=%0d writes=%0d want 0 0",
                     ecc_sb_count, wr_cnt - w0);
        end
        req(32'h40, 1'b0, 32'h0, 4'h0, h, d, e, c, sp, dp);
        vec++;
        if (d !== 32'h99BB33DD || h !== 1) begin
            miss++;
            $display("FAIL rst_mid_old_data: got %h holds=%0d want 99bb33dd 1", d, h);
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_protection();
        test_back_to_back();
        test_ecc();
        test_reset_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mci_mcu_sram_ctrl.md
# mci_mcu_sram_ctrl

Converts MCU SRAM requests from the MCI AXI subordinate decoder into accesses on a single-port, 1-cycle-latency SRAM macro. It sits directly downstream of the decoder's MCU SRAM request port. It provides:
- a read wait state;
- read-modify-write for partial-strobe writes;
- write protection of the firmware execution region;
- optional SECDED ECC.

## Interface
Parameters:
- MCU_SRAM_SIZE_KB, 512: SRAM capacity. Word-address width is SRAM_AW = $clog2(MCU_SRAM_SIZE_KB*256).

Ports:
- clk  in  1  block clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- cif_dv  in  1  request valid; held stable while cif_hold=1.
- cif_addr  in  32  byte address; bits [SRAM_AW+1:2] select the word; other bits are ignored.
- cif_write  in  1  1 = write.
- cif_wdata  in  32  write data.
- cif_wstrb  in  4  byte strobes.
- axi_mcu_req  in  1  request comes from the MCU (LSU/IFU user).
- axi_mcu_sram_config_req  in  1  request comes from the SRAM-config user.
- cif_hold  out  1  stall; the request completes in a cycle with cif_dv & ~cif_hold.
- cif_rdata  out  32  read data, valid in the completion cycle, otherwise 0.
- cif_error  out  1  error response in the completion cycle.
- fw_exec_region_lock  in  1  region-ownership select.
- exec_region_size  in  16  execution region is words [0, (exec_region_size+1)*1024).
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  39  {ecc[6:0], data[31:0]}.
- sram_rdata  in  39  SRAM read data, valid the cycle after a read with sram_cs.
- ecc_sb_err  out  1  1-cycle pulse on a corrected single-bit error.
- ecc_db_err  out  1  1-cycle pulse on an uncorrectable double-bit error.
- ecc_sb_count  out  16  saturating count of single-bit errors.

## Operation
- FSM states: IDLE, RD_DATA, RMW_RD, RMW_WR. All registers and outputs reset to 0; the FSM resets to IDLE.
- Protection check, evaluated in IDLE for writes whose word index falls in the execution region:
  - fw_exec_region_lock=1: only axi_mcu_req may write.
  - fw_exec_region_lock=0: only axi_mcu_sram_config_req may write.
  - Violation: cif_error=1 and cif_hold=0 in the same cycle, no SRAM access, stay in IDLE.
- Writes outside the execution region and all reads are unrestricted.
- IDLE actions:
  - Read: sram_cs=1, sram_we=0, cif_hold=1, go to RD_DATA.
  - Write with wstrb=4'hF: sram_cs=1, sram_we=1, wdata encoded, cif_hold=0, completes this cycle.
  - Write with wstrb≠4'hF: issue a read, cif_hold=1, go to RMW_RD. wstrb=0 is treated as partial and writes back unchanged data.
- RD_DATA: decode sram_rdata and drive cif_rdata; cif_hold=0; go to IDLE.
- RMW_RD: merge the corrected read word with the strobed bytes of cif_wdata into a merge register; cif_hold=1; go to RMW_WR.
- RMW_WR: write the merge register; cif_hold=0; go to IDLE.
- Double-bit error:
  - In RD_DATA: cif_rdata=0, cif_error=1.
  - In RMW_RD: go straight to IDLE with cif_error=1 and cif_hold=0; no write is issued.
- cif_dv dropping while the FSM is not in IDLE is illegal and is caught by an assertion.
- Reset mid-transaction: the FSM aborts to IDLE and sram_cs deasserts immediately. ecc_sb_count clears.
- ecc_sb_count saturates at 16'hFFFF. A simultaneous single-bit error and reset: reset wins.

## Timing
- Full-strobe write: 0 wait cycles.
- Read: 1 wait cycle; data returns in the completion cycle.
- Partial write: 2 wait cycles; the SRAM write occurs in the completion cycle.
- A back-to-back request is accepted the cycle after completion, since the FSM is then in IDLE.
- ecc_sb_err and ecc_db_err pulse in the completion cycle of RD_DATA, or in RMW_RD. They are registered and visible one cycle later.

## Configuration
MCI_MCU_SRAM_ECC_EN.
- Defined:
  - Hamming SECDED (39,32) encode on every write; check/correct on every read.
  - Corrected data is used for both cif_rdata and the RMW merge.
  - Corrected errors are not written back unless an RMW occurs.
- Undefined:
  - sram_wdata[38:32]=0 and sram_rdata[38:32] is ignored.
  - ecc_sb_err, ecc_db_err and ecc_sb_count are tied to 0; cif_error comes from protection only.

## Structure
- mci_pkg:
  - typedef enum for the FSM (mci_mcu_sram_state_e).
  - MCI_MCU_SRAM_ECC_W=7.
  - MCI_MCU_SRAM_EXEC_GRAN_WORDS=1024.
- Sub-module mci_mcu_sram_secded: purely combinational encode(data→ecc) and decode(data, ecc→corrected, sb, db). Instantiated only under MCI_MCU_SRAM_ECC_EN.

## Test plan
- Full write then read: write 0xDEADBEEF to word 0x40 with wstrb=F → completes with no hold; the read has hold=1 for 1 cycle, then cif_rdata=0xDEADBEEF.
- Partial write: word 0x10 holds 0x11223344; write 0xAABBCCDD with wstrb=4'b0101 → 2 hold cycles, then a read returns 0x11BB33DD.
- Protection:
  - lock=1, exec_region_size=0, non-MCU write to word 0x3FF → cif_error=1, no sram_cs.
  - The same write to word 0x400 → succeeds.
  - lock=0 with axi_mcu_sram_config_req → the word 0x3FF write succeeds.
- ECC single-bit: flip sram_rdata bit 5 → corrected data returned, ecc_sb_err pulses, ecc_sb_count=1, cif_error=0.
- ECC double-bit: flip bits 3 and 9 → cif_rdata=0, cif_error=1, ecc_db_err pulses.
- ECC double-bit during a partial write → cif_error=1 and no SRAM write is issued.
- Reset asserted in RMW_RD → the FSM returns to IDLE, sram_cs=0, no write; the next read returns the old data.
